// File: rtl/byte_decode_unpacker.sv
// Unpacks an LSB-first byte stream of packed d-bit fields into 16-bit coefficients, N per job (d=12 reduced mod Q).
// Latency: 2 cycles from the accept of the byte completing a field to out_valid rising.
// Backpressure: out_ready low holds the output register and stalls extraction; in_ready drops once >15 bits are buffered.
module byte_decode_unpacker #(
    parameter int Q     = 3329,
    parameter int N     = 256,
    parameter int ACC_W = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  d,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_coef,
    output logic [3:0]  out_d,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int BC_W = $clog2(ACC_W + 1);
    localparam int BL_W = $clog2(32 * 12 + 1);
    localparam int CC_W = $clog2(N + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        d_cfg_q, d_cfg_d;
    logic [BL_W-1:0]   bytes_left_q, bytes_left_d;
    logic [CC_W-1:0]   coef_cnt_q, coef_cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [15:0]       coef_q, coef_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              d_legal;
    logic              extract;
    logic              in_acc;
    logic              out_hs;
    logic [15:0]       field_mask;
    logic [15:0]       field;
    logic [15:0]       coef_map;
    logic [ACC_W-1:0]  acc_x;
    logic [BC_W-1:0]   bit_cnt_x;

    assign d_legal  = d inside {4'd1, 4'd4, 4'd5, 4'd10, 4'd11, 4'd12};
    assign in_ready = (state_q == RUN) && (bytes_left_q != '0)
                      && (bit_cnt_q <= BC_W'(ACC_W - 9));
    assign in_acc   = in_valid && in_ready;
    assign out_hs   = valid_q && out_ready;
    assign extract  = (state_q == RUN) && (bit_cnt_q >= BC_W'(d_cfg_q))
                      && (!valid_q || out_ready);

    assign field_mask = (16'd1 << d_cfg_q) - 16'd1;
    assign field      = acc_q[15:0] & field_mask;
    // Only 12-bit fields can reach Q; smaller widths pass through untouched.
    assign coef_map   = ((d_cfg_q == 4'd12) && (field >= 16'(Q))) ? field - 16'(Q) : field;

    always_comb begin
        state_d      = state_q;
        d_cfg_d      = d_cfg_q;
        bytes_left_d = bytes_left_q;
        coef_cnt_d   = coef_cnt_q;
        acc_d        = acc_q;
        bit_cnt_d    = bit_cnt_q;
        coef_d       = coef_q;
        valid_d      = valid_q;
        last_d       = last_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        acc_x        = acc_q;
        bit_cnt_x    = bit_cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (d_legal) begin
                        state_d      = RUN;
                        d_cfg_d      = d;
                        bytes_left_d = BL_W'({d, 5'b00000});
                        coef_cnt_d   = '0;
                        acc_d        = '0;
                        bit_cnt_d    = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (out_hs) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
                if (extract) begin
                    acc_x      = acc_q >> d_cfg_q;
                    bit_cnt_x  = bit_cnt_q - BC_W'(d_cfg_q);
                    coef_d     = coef_map;
                    valid_d    = 1'b1;
                    last_d     = (coef_cnt_q == CC_W'(N - 1));
                    coef_cnt_d = coef_cnt_q + CC_W'(1);
                end
                acc_d     = acc_x;
                bit_cnt_d = bit_cnt_x;
                // A byte arriving with an extraction lands above the already-shifted remainder.
                if (in_acc) begin
                    acc_d        = acc_x | (ACC_W'(in_data) << bit_cnt_x);
                    bit_cnt_d    = bit_cnt_x + BC_W'(8);
                    bytes_left_d = bytes_left_q - BL_W'(1);
                end
                if (out_hs && last_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            d_cfg_q      <= '0;
            bytes_left_q <= '0;
            coef_cnt_q   <= '0;
            acc_q        <= '0;
            bit_cnt_q    <= '0;
            coef_q       <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            d_cfg_q      <= d_cfg_d;
            bytes_left_q <= bytes_left_d;
            coef_cnt_q   <= coef_cnt_d;
            acc_q        <= acc_d;
            bit_cnt_q    <= bit_cnt_d;
            coef_q       <= coef_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign out_coef  = coef_q;
    assign out_d     = d_cfg_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_byte_decode_unpacker.sv
// Randomized bench for byte_decode_unpacker; expected coefficients come from a bit-array model of the packed stream.
module tb_byte_decode_unpacker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  d = 4'd0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_coef;
    logic [3:0]  out_d;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] tx_q[$];
    int         rx_coef[$];
    bit         rx_last[$];
    int         idx;
    bit         done_at_end;
    bit         busy_at_end;

    byte_decode_unpacker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .d(d),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_coef(out_coef), .out_d(out_d), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Coefficient j is bits [j*dd +: dd] of the concatenated byte stream, LSB-first.
    function automatic int model_coef(input int dd, input int j);
        int v;
        int b;
        logic [7:0] byt;
        v = 0;
        for (int k = 0; k < dd; k++) begin
            b = j * dd + k;
            byt = tx_q[b / 8];
            if (byt[b % 8]) v = v | (1 << k);
        end
        if (dd == 12 && v >= 3329) v = v - 3329;
        return v;
    endfunction

    task automatic new_job();
        tx_q.delete();
        rx_coef.delete();
        rx_last.delete();
        idx = 0;
    endtask

    task automatic fill_random(input int nbytes);
        for (int i = 0; i < nbytes; i++) tx_q.push_back(8'($urandom));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_job(input int dd);
        start = 1'b1;
        d = 4'(dd);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_io(input int want, input int rdy_pct, input int vld_pct, output bit to);
        int cyc;
        cyc = 0;
        to = 1'b0;
        while (rx_coef.size() < want) begin
            if (cyc >= 20000) begin
                to = 1'b1;
                break;
            end
            in_valid  = (idx < tx_q.size()) && (int'($urandom_range(99)) < vld_pct);
            in_data   = (idx < tx_q.size()) ? tx_q[idx] : 8'h00;
            out_ready = (int'($urandom_range(99)) < rdy_pct);
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                rx_coef.push_back(int'(out_coef));
                rx_last.push_back(out_last);
            end
            @(negedge clk);
            cyc++;
        end
        done_at_end = done;
        busy_at_end = busy;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (out_last !== 1'b0)   begin n_fail++; $display("FAIL reset_out_last got %b want 0", out_last); end
        n_checks++; if (out_coef !== 16'd0)  begin n_fail++; $display("FAIL reset_out_coef got %0d want 0", out_coef); end
        n_checks++; if (out_d !== 4'd0)      begin n_fail++; $display("FAIL reset_out_d got %0d want 0", out_d); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0)       begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (err !== 1'b0)        begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_release busy %b in_ready %b want 0 0", busy, in_ready); end
    endtask

    task automatic test_d1();
        bit to;
        new_job();
        tx_q.push_back(8'h01);
        for (int i = 0; i < 31; i++) tx_q.push_back(8'h00);
        for (int i = 0; i < 4; i++) tx_q.push_back(8'hAA);
        start_job(1);
        n_checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL d1_cycle1 busy %b in_ready %b want 1 1", busy, in_ready); end
        n_checks++; if (out_d !== 4'd1) begin n_fail++; $display("FAIL d1_out_d got %0d want 1", out_d); end
        start = 1'b1; d = 4'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_checks++; if (err !== 1'b0 || out_d !== 4'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL d1_start_in_run err %b out_d %0d busy %b want 0 1 1", err, out_d, busy); end
        run_io(256, 100, 100, to);
        n_checks++; if (to || rx_coef.size() != 256) begin n_fail++; $display("FAIL d1_count got %0d coefs want 256", rx_coef.size()); end
        n_checks++; if (rx_coef.size() > 0 && rx_coef[0] !== 1) begin n_fail++; $display("FAIL d1_first got %0d want 1", rx_coef[0]); end
        for (int i = 0; i < rx_coef.size(); i++) begin
            n_checks++;
            if (rx_coef[i] !== model_coef(1, i) || rx_last[i] !== (i == 255)) begin
                n_fail++; $display("FAIL d1_coef[%0d] got %0d last %b want %0d last %b", i, rx_coef[i], rx_last[i], model_coef(1, i), (i == 255));
            end
        end
        n_checks++; if (done_at_end !== 1'b1 || busy_at_end !== 1'b0) begin n_fail++; $display("FAIL d1_done done %b busy %b want 1 0", done_at_end, busy_at_end); end
        n_checks++; if (idx !== 32) begin n_fail++; $display("FAIL d1_bytes_accepted got %0d want 32", idx); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL d1_done_pulse got %b want 0", done); end
    endtask

    task automatic test_d12_reduce();
        bit to;
        new_job();
        tx_q.push_back(8'h01); tx_q.push_back(8'hF0); tx_q.push_back(8'hFF);
        start_job(12);
        run_io(2, 100, 100, to);
        n_checks++; if (to || rx_coef.size() != 2) begin n_fail++; $display("FAIL d12_count got %0d want 2", rx_coef.size()); end
        else begin
            n_checks++; if (rx_coef[0] !== 1)   begin n_fail++; $display("FAIL d12_coef0 got %0d want 1", rx_coef[0]); end
            n_checks++; if (rx_coef[1] !== 766) begin n_fail++; $display("FAIL d12_coef1 got %0d want 766", rx_coef[1]); end
            n_checks++; if (rx_last[0] || rx_last[1]) begin n_fail++; $display("FAIL d12_last got %b%b want 00", rx_last[0], rx_last[1]); end
        end
        n_checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL d12_still_running busy %b in_ready %b want 1 1", busy, in_ready); end
        do_reset();
    endtask

    task automatic test_d10_align();
        bit to;
        new_job();
        for (int i = 0; i < 5; i++) tx_q.push_back(8'hFF);
        fill_random(5);
        start_job(10);
        run_io(8, 70, 80, to);
        n_checks++; if (to || rx_coef.size() != 8) begin n_fail++; $display("FAIL d10_count got %0d want 8", rx_coef.size()); end
        for (int i = 0; i < rx_coef.size(); i++) begin
            n_checks++;
            if (rx_coef[i] !== model_coef(10, i) || (i < 4 && rx_coef[i] !== 1023)) begin
                n_fail++; $display("FAIL d10_coef[%0d] got %0d want %0d", i, rx_coef[i], model_coef(10, i));
            end
        end
        do_reset();
    endtask

    task automatic test_backpressure_d4();
        bit to;
        bit got;
        logic [15:0] held;
        new_job();
        fill_random(128);
        start_job(4);
        out_ready = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (out_valid) got = 1'b1;
            else begin
                in_valid = 1'b1; in_data = tx_q[idx];
                if (in_ready) idx++;
                @(negedge clk);
            end
        end
        n_checks++; if (!got) begin n_fail++; $display("FAIL bp_first_valid got none within 20 cycles want out_valid"); end
        held = out_coef;
        n_checks++; if (int'(held) !== model_coef(4, 0)) begin n_fail++; $display("FAIL bp_first_coef got %0d want %0d", held, model_coef(4, 0)); end
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; in_data = tx_q[idx];
            if (in_ready) idx++;
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_coef !== held || out_last !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold[%0d] valid %b coef %0d last %b want 1 %0d 0", c, out_valid, out_coef, out_last, held);
            end
        end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        n_checks++; if (idx !== 3) begin n_fail++; $display("FAIL bp_bytes_during_stall got %0d want 3", idx); end
        run_io(256, 60, 70, to);
        n_checks++; if (to || rx_coef.size() != 256) begin n_fail++; $display("FAIL bp_count got %0d want 256", rx_coef.size()); end
        for (int i = 0; i < rx_coef.size(); i++) begin
            n_checks++;
            if (rx_coef[i] !== model_coef(4, i) || rx_last[i] !== (i == 255)) begin
                n_fail++; $display("FAIL bp_coef[%0d] got %0d last %b want %0d last %b", i, rx_coef[i], rx_last[i], model_coef(4, i), (i == 255));
            end
        end
        n_checks++; if (done_at_end !== 1'b1) begin n_fail++; $display("FAIL bp_done got %b want 1", done_at_end); end
    endtask

    task automatic test_illegal_d();
        start = 1'b1; d = 4'd7;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL illegal_err err %b busy %b in_ready %b want 1 0 0", err, busy, in_ready); end
        @(negedge clk);
        n_checks++; if (err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL illegal_after err %b busy %b in_ready %b want 0 0 0", err, busy, in_ready); end
    endtask

    task automatic test_reset_midjob();
        bit to;
        new_job();
        fill_random(352);
        start_job(11);
        run_io(40, 80, 80, to);
        n_checks++; if (to || rx_coef.size() != 40) begin n_fail++; $display("FAIL mid_count got %0d want 40", rx_coef.size()); end
        in_valid = 1'b1; in_data = 8'($urandom); out_ready = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_coef !== 16'd0 ||
            out_d !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset rdy %b vld %b last %b coef %0d d %0d busy %b done %b err %b want all 0",
                                in_ready, out_valid, out_last, out_coef, out_d, busy, done, err);
        end
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_no_done done %b busy %b want 0 0", done, busy); end
        new_job();
        fill_random(352);
        start_job(11);
        run_io(256, 75, 75, to);
        n_checks++; if (to || rx_coef.size() != 256) begin n_fail++; $display("FAIL mid_restart_count got %0d want 256", rx_coef.size()); end
        for (int i = 0; i < rx_coef.size(); i++) begin
            n_checks++;
            if (rx_coef[i] !== model_coef(11, i) || rx_last[i] !== (i == 255)) begin
                n_fail++; $display("FAIL mid_coef[%0d] got %0d last %b want %0d last %b", i, rx_coef[i], rx_last[i], model_coef(11, i), (i == 255));
            end
        end
        n_checks++; if (done_at_end !== 1'b1) begin n_fail++; $display("FAIL mid_restart_done got %b want 1", done_at_end); end
    endtask

    task automatic test_back_to_back();
        bit to;
        new_job();
        fill_random(160);
        start_job(5);
        run_io(256, 80, 90, to);
        n_checks++; if (to || rx_coef.size() != 256) begin n_fail++; $display("FAIL b2b_d5_count got %0d want 256", rx_coef.size()); end
        for (int i = 0; i < rx_coef.size(); i++) begin
            n_checks++;
            if (rx_coef[i] !== model_coef(5, i) || rx_last[i] !== (i == 255)) begin
                n_fail++; $display("FAIL b2b_d5_coef[%0d] got %0d want %0d", i, rx_coef[i], model_coef(5, i));
            end
        end
        n_checks++; if (done_at_end !== 1'b1) begin n_fail++; $display("FAIL b2b_d5_done got %b want 1", done_at_end); end
        new_job();
        fill_random(384);
        start_job(12);
        n_checks++; if (busy !== 1'b1 || out_d !== 4'd12) begin n_fail++; $display("FAIL b2b_restart busy %b out_d %0d want 1 12", busy, out_d); end
        run_io(256, 70, 85, to);
        n_checks++; if (to || rx_coef.size() != 256) begin n_fail++; $display("FAIL b2b_d12_count got %0d want 256", rx_coef.size()); end
        for (int i = 0; i < rx_coef.size(); i++) begin
            n_checks++;
            if (rx_coef[i] !== model_coef(12, i) || rx_last[i] !== (i == 255)) begin
                n_fail++; $display("FAIL b2b_d12_coef[%0d] got %0d want %0d", i, rx_coef[i], model_coef(12, i));
            end
        end
        n_checks++; if (done_at_end !== 1'b1 || busy_at_end !== 1'b0) begin n_fail++; $display("FAIL b2b_d12_done done %b busy %b want 1 0", done_at_end, busy_at_end); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_d1();
        test_d12_reduce();
        test_d10_align();
        test_backpressure_d4();
        test_illegal_d();
        test_reset_midjob();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
